// File: rtl/nv_nvdla_pdp_wdma_pack.sv
// Packs the PDP core's one-element-per-cycle output into ATOM_BYTES-wide write-DMA words.
// Flushes a partial word at every line end and tags line/cube boundaries.
module nv_nvdla_pdp_wdma_pack #(
    parameter int ATOM_BYTES = 8,
    parameter int BPE        = 8
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    input  logic                         reg2dp_op_en,
    input  logic [12:0]                  reg2dp_cube_out_width,
    input  logic [12:0]                  reg2dp_cube_out_height,
    input  logic [12:0]                  reg2dp_cube_out_channel,
    input  logic [BPE-1:0]               pdp_dp2wdma_pd,
    input  logic                         pdp_dp2wdma_valid,
    output logic                         pdp_dp2wdma_ready,
    output logic [ATOM_BYTES*BPE-1:0]    wdma_pack_pd,
    output logic [ATOM_BYTES-1:0]        wdma_pack_mask,
    output logic                         wdma_pack_last_line,
    output logic                         wdma_pack_last_cube,
    output logic                         wdma_pack_valid,
    input  logic                         wdma_pack_ready,
    output logic                         wdma_pack_done
);

    localparam int CNTB_W = $clog2(ATOM_BYTES);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                 state_reg;
    logic [12:0]                width_reg, height_reg, channel_reg;
    logic [12:0]                cnt_x_reg, cnt_y_reg, cnt_c_reg;
    logic [CNTB_W-1:0]          cnt_b_reg;
    logic                       cube_end_reg;
    logic [BPE-1:0]             stage_reg [ATOM_BYTES];
    logic [ATOM_BYTES*BPE-1:0]  pd_reg, word_next;
    logic [ATOM_BYTES-1:0]      mask_reg, mask_next;
    logic                       last_line_reg, last_cube_reg, valid_reg;

    logic start, line_end, word_end, cube_end, elem_acc, xfer, out_acc;

    assign start    = (state_reg == ST_IDLE) && reg2dp_op_en;
    assign line_end = (cnt_x_reg == width_reg);
    assign word_end = line_end || (cnt_b_reg == CNTB_W'(ATOM_BYTES - 1));
    assign cube_end = line_end && (cnt_y_reg == height_reg) && (cnt_c_reg == channel_reg);

    // Ready is built from registers and the downstream ready only, so the
    // upstream never sees a combinational path back from its own valid.
    assign pdp_dp2wdma_ready = (state_reg == ST_RUN) && !cube_end_reg &&
                               (!word_end || !valid_reg || wdma_pack_ready);
    assign elem_acc = pdp_dp2wdma_valid && pdp_dp2wdma_ready;
    assign xfer     = elem_acc && word_end;
    assign out_acc  = valid_reg && wdma_pack_ready;

    // Staging bytes above cnt_b are always zero because staging is cleared on every transfer.
    genvar gi;
    generate
        for (gi = 0; gi < ATOM_BYTES; gi++) begin : g_byte
            assign word_next[gi*BPE +: BPE] = (cnt_b_reg == CNTB_W'(gi)) ? pdp_dp2wdma_pd : stage_reg[gi];
            assign mask_next[gi] = (CNTB_W'(gi) <= cnt_b_reg);

            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    stage_reg[gi] <= '0;
                end else if (start || xfer) begin
                    stage_reg[gi] <= '0;
                end else if (elem_acc && (cnt_b_reg == CNTB_W'(gi))) begin
                    stage_reg[gi] <= pdp_dp2wdma_pd;
                end
            end
        end
    endgenerate

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (reg2dp_op_en) state_reg <= ST_RUN;
                ST_RUN:  if (out_acc && last_cube_reg) state_reg <= ST_DONE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            width_reg    <= '0;
            height_reg   <= '0;
            channel_reg  <= '0;
            cnt_b_reg    <= '0;
            cnt_x_reg    <= '0;
            cnt_y_reg    <= '0;
            cnt_c_reg    <= '0;
            cube_end_reg <= 1'b0;
        end else if (start) begin
            width_reg    <= reg2dp_cube_out_width;
            height_reg   <= reg2dp_cube_out_height;
            channel_reg  <= reg2dp_cube_out_channel;
            cnt_b_reg    <= '0;
            cnt_x_reg    <= '0;
            cnt_y_reg    <= '0;
            cnt_c_reg    <= '0;
            cube_end_reg <= 1'b0;
        end else if (elem_acc) begin
            if (xfer) begin
                cnt_b_reg <= '0;
                if (cube_end) cube_end_reg <= 1'b1;
                if (line_end) begin
                    cnt_x_reg <= '0;
                    if (cnt_y_reg == height_reg) begin
                        cnt_y_reg <= '0;
                        cnt_c_reg <= cnt_c_reg + 13'd1;
                    end else begin
                        cnt_y_reg <= cnt_y_reg + 13'd1;
                    end
                end else begin
                    cnt_x_reg <= cnt_x_reg + 13'd1;
                end
            end else begin
                cnt_b_reg <= cnt_b_reg + CNTB_W'(1);
                cnt_x_reg <= cnt_x_reg + 13'd1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pd_reg        <= '0;
            mask_reg      <= '0;
            last_line_reg <= 1'b0;
            last_cube_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else if (xfer) begin
            pd_reg        <= word_next;
            mask_reg      <= mask_next;
            last_line_reg <= line_end;
            last_cube_reg <= cube_end;
            valid_reg     <= 1'b1;
        end else if (out_acc) begin
            valid_reg     <= 1'b0;
        end
    end

    assign wdma_pack_pd        = pd_reg;
    assign wdma_pack_mask      = mask_reg;
    assign wdma_pack_last_line = last_line_reg;
    assign wdma_pack_last_cube = last_cube_reg;
    assign wdma_pack_valid     = valid_reg;
    assign wdma_pack_done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_pack.sv
// Directed+random bench for nv_nvdla_pdp_wdma_pack against a line/word reference model.
module tb_nv_nvdla_pdp_wdma_pack;

    localparam int AB  = 8;
    localparam int BPE = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_en;
    logic [12:0]       cw, ch, cc;
    logic [BPE-1:0]    in_pd;
    logic              in_valid;
    logic              in_ready;
    logic [AB*BPE-1:0] out_pd;
    logic [AB-1:0]     out_mask;
    logic              out_ll, out_lc, out_valid, out_ready, out_done;

    always #5 clk = ~clk;

    nv_nvdla_pdp_wdma_pack #(.ATOM_BYTES(AB), .BPE(BPE)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rst_n),
        .reg2dp_op_en            (op_en),
        .reg2dp_cube_out_width   (cw),
        .reg2dp_cube_out_height  (ch),
        .reg2dp_cube_out_channel (cc),
        .pdp_dp2wdma_pd          (in_pd),
        .pdp_dp2wdma_valid       (in_valid),
        .pdp_dp2wdma_ready       (in_ready),
        .wdma_pack_pd            (out_pd),
        .wdma_pack_mask          (out_mask),
        .wdma_pack_last_line     (out_ll),
        .wdma_pack_last_cube     (out_lc),
        .wdma_pack_valid         (out_valid),
        .wdma_pack_ready         (out_ready),
        .wdma_pack_done          (out_done)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0]  elems[$];
    logic [63:0] wpd[$];
    logic [7:0]  wmask[$];
    bit          wll[$];
    bit          wlc[$];
    int          mw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: walk the cube line by line and cut each line into AB-element chunks.
    task automatic build(input int w, input int h, input int c, input bit seq);
        logic [63:0] word;
        int b, idx;
        elems.delete(); wpd.delete(); wmask.delete(); wll.delete(); wlc.delete();
        idx = 0;
        for (int s = 0; s <= c; s++)
            for (int y = 0; y <= h; y++) begin
                word = '0;
                b = 0;
                for (int x = 0; x <= w; x++) begin
                    logic [7:0] e;
                    e = seq ? 8'(idx) : 8'($urandom);
                    idx++;
                    elems.push_back(e);
                    word[b*8 +: 8] = e;
                    if (b == AB - 1 || x == w) begin
                        wpd.push_back(word);
                        wmask.push_back(8'((1 << (b + 1)) - 1));
                        wll.push_back(x == w);
                        wlc.push_back(x == w && y == h && s == c);
                        word = '0;
                        b = 0;
                    end else begin
                        b++;
                    end
                end
            end
    endtask

    function automatic bit completes(input int ei);
        int x;
        x = ei % (mw + 1);
        return (x == mw) || (x % AB == AB - 1);
    endfunction

    task automatic run_op(input int w, input int h, input int c, input bit seq,
                          input int vprob, input int rprob, input int stall, input int abort_at);
        int ei, wi, pending, stall_left, cycles, n, nwords;
        bit dv, dr, rdy_exp, done_exp, done_was, out_acc, in_acc, finished;
        build(w, h, c, seq);
        mw = w;
        n = elems.size();
        nwords = wpd.size();
        @(negedge clk);
        cw = 13'(w); ch = 13'(h); cc = 13'(c);
        op_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("idle_ready", in_ready, 0);
        @(negedge clk);
        op_en = 1'b0;
        cw = 13'($urandom); ch = 13'($urandom); cc = 13'($urandom);
        ei = 0; wi = 0; pending = 0; stall_left = -1; cycles = 0;
        done_exp = 0; finished = 0;
        forever begin
            dv = (ei < n) && ($urandom_range(99) < vprob);
            dr = $urandom_range(99) < rprob;
            if (stall > 0 && stall_left < 0 && pending > 0) stall_left = stall;
            if (stall_left > 0) begin dr = 1'b0; stall_left--; end
            in_valid  = dv;
            in_pd     = dv ? elems[ei] : 8'($urandom);
            out_ready = dr;
            #1;
            rdy_exp = !finished && ei < n && (!completes(ei) || pending == 0 || dr);
            chk("in_ready", in_ready, rdy_exp);
            chk("out_valid", out_valid, pending > 0);
            chk("done", out_done, done_exp);
            if (pending > 0) begin
                chk("out_pd", out_pd, wpd[wi]);
                chk("out_mask", out_mask, wmask[wi]);
                chk("last_line", out_ll, wll[wi]);
                chk("last_cube", out_lc, wlc[wi]);
            end
            if (abort_at >= 0 && ei == abort_at) begin
                in_valid = 1'b0;
                out_ready = 1'b0;
                return;
            end
            done_was = done_exp;
            out_acc = pending > 0 && dr;
            in_acc  = dv && rdy_exp;
            done_exp = 0;
            if (out_acc) begin
                $display("word %0d: pd=%h mask=%h last_line=%0d last_cube=%0d",
                         wi, wpd[wi], wmask[wi], wll[wi], wlc[wi]);
                wi++;
                pending--;
                if (wi == nwords) begin finished = 1; done_exp = 1; end
            end
            if (in_acc) begin
                if (completes(ei)) pending++;
                ei++;
            end
            if (done_was) break;
            cycles++;
            if (cycles > 5000) begin chk("timeout", 0, 1); break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_done", out_done, 0);
        chk("post_ready", in_ready, 0);
        chk("post_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; op_en = 1'b0; cw = '0; ch = '0; cc = '0;
        in_pd = '0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pd", out_pd, 0);
        chk("rst_done", out_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(15, 0, 0, 1'b1, 100, 100, 0, -1);
        run_op(9, 1, 0, 1'b0, 100, 100, 0, -1);
        run_op(0, 2, 1, 1'b0, 100, 100, 0, -1);
        run_op(3, 1, 0, 1'b0, 100, 100, 5, -1);
        run_op(63, 0, 0, 1'b0, 100, 100, 0, -1);
        run_op(20, 2, 1, 1'b0, 70, 60, 0, -1);

        // Abort mid-word with reset, then a fresh single-word op.
        run_op(15, 0, 0, 1'b0, 100, 100, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_pd", out_pd, 0);
        chk("mid_rst_mask", out_mask, 0);
        chk("mid_rst_last", {out_ll, out_lc}, 0);
        chk("mid_rst_done", out_done, 0);
        @(negedge clk);
        #1 chk("rst_hold_done", out_done, 0);
        rst_n = 1'b1;
        run_op(7, 0, 0, 1'b1, 100, 100, 0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
